// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
// Holds CSR addresses, mstatus/mie/mip bit indices, trap cause codes and
// small address-classification helpers used by the decoder.
package csr_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned ADDR_W = 12;

  // Machine trap-setup / trap-handling CSRs
  localparam logic [ADDR_W-1:0] CSR_MSTATUS   = 12'h300;
  localparam logic [ADDR_W-1:0] CSR_MIE       = 12'h304;
  localparam logic [ADDR_W-1:0] CSR_MTVEC     = 12'h305;
  localparam logic [ADDR_W-1:0] CSR_MEPC      = 12'h341;
  localparam logic [ADDR_W-1:0] CSR_MCAUSE    = 12'h342;
  localparam logic [ADDR_W-1:0] CSR_MIP       = 12'h344;

  // Counters (read/write) and their user-level read-only shadows
  localparam logic [ADDR_W-1:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [ADDR_W-1:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [ADDR_W-1:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [ADDR_W-1:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [ADDR_W-1:0] CSR_CYCLE     = 12'hC00;
  localparam logic [ADDR_W-1:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [ADDR_W-1:0] CSR_INSTRET   = 12'hC02;
  localparam logic [ADDR_W-1:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [ADDR_W-1:0] CSR_MHARTID   = 12'hF14;

  // mstatus bit positions
  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // mie / mip bit positions
  localparam int unsigned MIE_MTIE = 7;
  localparam int unsigned MIE_MEIE = 11;
  localparam int unsigned MIP_MTIP = 7;
  localparam int unsigned MIP_MEIP = 11;

  // Trap cause codes (bit 31 marks an interrupt)
  localparam logic [XLEN-1:0] CAUSE_BREAKPOINT  = 32'h0000_0003;
  localparam logic [XLEN-1:0] CAUSE_M_TIMER_IRQ = 32'h8000_0007;
  localparam logic [XLEN-1:0] CAUSE_M_EXT_IRQ   = 32'h8000_000B;

  // True for every address this CSR file decodes
  function automatic logic csr_implemented(input logic [ADDR_W-1:0] addr);
    return addr inside {CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE,
                        CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH, CSR_MINSTRET,
                        CSR_MINSTRETH, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET,
                        CSR_INSTRETH, CSR_MHARTID};
  endfunction

  // True for decoded addresses that may not be written
  function automatic logic csr_read_only(input logic [ADDR_W-1:0] addr);
    return addr inside {CSR_MIP, CSR_CYCLE, CSR_CYCLEH, CSR_INSTRET,
                        CSR_INSTRETH, CSR_MHARTID};
  endfunction

endpackage

// File: rtl/csr_file_if.sv
// csr_file_if: CSR access bus between the core's CSR instruction path
// (master) and the CSR file (slave).
//   csr_addr    master->slave  CSR address of the current instruction
//   csr_we      master->slave  commit csr_wdata at the next rising edge
//   csr_wdata   master->slave  final write value (write/set/clear applied)
//   csr_rdata   slave->master  combinational read data (old value)
//   csr_illegal slave->master  unimplemented address or write to read-only
interface csr_file_if;
  import csr_pkg::*;

  logic [ADDR_W-1:0] csr_addr;
  logic              csr_we;
  logic [XLEN-1:0]   csr_wdata;
  logic [XLEN-1:0]   csr_rdata;
  logic              csr_illegal;

  modport master (
    output csr_addr, csr_we, csr_wdata,
    input  csr_rdata, csr_illegal
  );

  modport slave (
    input  csr_addr, csr_we, csr_wdata,
    output csr_rdata, csr_illegal
  );

endinterface

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter whose two 32-bit halves can be
// loaded independently. A load of either half replaces that cycle's
// increment and holds the other half.
//   clk, rst   clock, asynchronous active-high reset (count clears to 0)
//   i_inc      advance the count by one this cycle
//   i_we_lo    load bits [31:0] with i_wdata
//   i_we_hi    load bits [63:32] with i_wdata
//   i_wdata    load value
//   o_count    current 64-bit count
module csr_counter64 (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inc,
  input  logic        i_we_lo,
  input  logic        i_we_hi,
  input  logic [31:0] i_wdata,
  output logic [63:0] o_count
);

  localparam int unsigned CNT_W  = 64;
  localparam int unsigned HALF_W = 32;

  logic [CNT_W-1:0] r_count;

  // Half loads take precedence over counting; natural overflow gives the wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_we_lo) begin
      r_count[HALF_W-1:0] <= i_wdata;
    end else if (i_we_hi) begin
      r_count[CNT_W-1:HALF_W] <= i_wdata;
    end else if (i_inc) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file with trap entry/return, interrupt
// pending logic and the mcycle/minstret counters.
//   clk, rst      clock, asynchronous active-high reset
//   bus           csr_file_if.slave: addr/we/wdata in, rdata/illegal out
//   retire        one instruction retires this cycle (minstret++)
//   trap_req      trap entry; trap_cause/trap_pc give cause and faulting PC
//   mret          return-from-trap this cycle
//   ext_irq       level external interrupt (synchronous to clk)
//   timer_irq     level timer interrupt (synchronous to clk)
//   irq_pending   enabled interrupt that the core must take (combinational)
//   mtvec_out     current trap vector
//   mepc_out      current return PC
module csr_file
  import csr_pkg::*;
#(
  parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
  parameter logic [31:0] HART_ID   = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  csr_file_if.slave       bus,
  input  logic            retire,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret,
  input  logic            ext_irq,
  input  logic            timer_irq,
  output logic            irq_pending,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out
);

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  logic            r_mie;
  logic            r_mpie;
  logic            r_mtie;
  logic            r_meie;
  logic [XLEN-1:0] r_mtvec;
  logic [XLEN-1:0] r_mepc;
  logic [XLEN-1:0] r_mcause;

  logic            w_illegal;
  logic            w_wr;
  logic [XLEN-1:0] w_rdata;
  logic [63:0]     w_mcycle;
  logic [63:0]     w_minstret;

  // Address classification; only legal writes reach any register
  assign w_illegal = ~csr_implemented(bus.csr_addr) |
                     (bus.csr_we & csr_read_only(bus.csr_addr));
  assign w_wr      = bus.csr_we & ~w_illegal;

  csr_counter64 u_mcycle (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (1'b1),
    .i_we_lo (w_wr && (bus.csr_addr == CSR_MCYCLE)),
    .i_we_hi (w_wr && (bus.csr_addr == CSR_MCYCLEH)),
    .i_wdata (bus.csr_wdata),
    .o_count (w_mcycle)
  );

  csr_counter64 u_minstret (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (retire),
    .i_we_lo (w_wr && (bus.csr_addr == CSR_MINSTRET)),
    .i_we_hi (w_wr && (bus.csr_addr == CSR_MINSTRETH)),
    .i_wdata (bus.csr_wdata),
    .o_count (w_minstret)
  );

  // Trap state: trap entry beats mret, which beats software writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mie    <= 1'b0;
      r_mpie   <= 1'b0;
      r_mepc   <= '0;
      r_mcause <= '0;
    end else if (trap_req) begin
      r_mepc   <= trap_pc & ALIGN_MASK;
      r_mcause <= trap_cause;
      r_mpie   <= r_mie;
      r_mie    <= 1'b0;
    end else if (mret) begin
      r_mie    <= r_mpie;
      r_mpie   <= 1'b1;
    end else if (w_wr) begin
      case (bus.csr_addr)
        CSR_MSTATUS: begin
          r_mie  <= bus.csr_wdata[MSTATUS_MIE];
          r_mpie <= bus.csr_wdata[MSTATUS_MPIE];
        end
        CSR_MEPC:   r_mepc   <= bus.csr_wdata & ALIGN_MASK;
        CSR_MCAUSE: r_mcause <= bus.csr_wdata;
        default: ;
      endcase
    end
  end

  // Interrupt enables and trap vector are never overridden by trap/mret
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mtie  <= 1'b0;
      r_meie  <= 1'b0;
      r_mtvec <= MTVEC_RST;
    end else if (w_wr) begin
      case (bus.csr_addr)
        CSR_MIE: begin
          r_mtie <= bus.csr_wdata[MIE_MTIE];
          r_meie <= bus.csr_wdata[MIE_MEIE];
        end
        CSR_MTVEC: r_mtvec <= bus.csr_wdata & ALIGN_MASK;
        default: ;
      endcase
    end
  end

  // Zero-latency read mux; unimplemented addresses read 0
  always_comb begin
    w_rdata = '0;
    case (bus.csr_addr)
      CSR_MSTATUS: begin
        w_rdata[MSTATUS_MIE]                   = r_mie;
        w_rdata[MSTATUS_MPIE]                  = r_mpie;
        w_rdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
      end
      CSR_MIE: begin
        w_rdata[MIE_MTIE] = r_mtie;
        w_rdata[MIE_MEIE] = r_meie;
      end
      CSR_MIP: begin
        w_rdata[MIP_MTIP] = timer_irq;
        w_rdata[MIP_MEIP] = ext_irq;
      end
      CSR_MTVEC:                   w_rdata = r_mtvec;
      CSR_MEPC:                    w_rdata = r_mepc;
      CSR_MCAUSE:                  w_rdata = r_mcause;
      CSR_MCYCLE,    CSR_CYCLE:    w_rdata = w_mcycle[31:0];
      CSR_MCYCLEH,   CSR_CYCLEH:   w_rdata = w_mcycle[63:32];
      CSR_MINSTRET,  CSR_INSTRET:  w_rdata = w_minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: w_rdata = w_minstret[63:32];
      CSR_MHARTID:                 w_rdata = HART_ID;
      default: ;
    endcase
  end

  assign bus.csr_rdata   = w_rdata;
  assign bus.csr_illegal = w_illegal;

  assign irq_pending = r_mie & ((ext_irq & r_meie) | (timer_irq & r_mtie));
  assign mtvec_out   = r_mtvec;
  assign mepc_out    = r_mepc;

endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed and randomized bench for csr_file against a
// behavioural CSR model held in plain variables.
module tb_csr_file;
  import csr_pkg::*;

  localparam logic [31:0] P_MTVEC_RST = 32'h8000_0100;
  localparam logic [31:0] P_HART_ID   = 32'h0000_0005;

  logic        clk = 1'b0;
  logic        rst;
  logic        retire, trap_req, mret, ext_irq, timer_irq;
  logic [31:0] trap_cause, trap_pc;
  logic        irq_pending;
  logic [31:0] mtvec_out, mepc_out;

  csr_file_if bus ();

  csr_file #(.MTVEC_RST(P_MTVEC_RST), .HART_ID(P_HART_ID)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .retire      (retire),
    .trap_req    (trap_req),
    .trap_cause  (trap_cause),
    .trap_pc     (trap_pc),
    .mret        (mret),
    .ext_irq     (ext_irq),
    .timer_irq   (timer_irq),
    .irq_pending (irq_pending),
    .mtvec_out   (mtvec_out),
    .mepc_out    (mepc_out)
  );

  always #10 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_mie, m_mpie;
  logic [31:0] m_ie, m_tvec, m_epc, m_cause;
  logic [63:0] m_cyc, m_ins;

  function automatic logic m_impl(input logic [11:0] a);
    return a inside {12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                     12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                     12'hC02, 12'hC82, 12'hF14};
  endfunction

  function automatic logic m_ro(input logic [11:0] a);
    return a inside {12'h344, 12'hC00, 12'hC80, 12'hC02, 12'hC82, 12'hF14};
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h304: return m_ie;
      12'h305: return m_tvec;
      12'h341: return m_epc;
      12'h342: return m_cause;
      12'h344: return (32'(timer_irq) << 7) | (32'(ext_irq) << 11);
      12'hB00, 12'hC00: return m_cyc[31:0];
      12'hB80, 12'hC80: return m_cyc[63:32];
      12'hB02, 12'hC02: return m_ins[31:0];
      12'hB82, 12'hC82: return m_ins[63:32];
      12'hF14: return P_HART_ID;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin
    logic        w, old_mie, old_mpie;
    logic [11:0] a;
    logic [31:0] d;
    if (rst) begin
      m_mie = 1'b0; m_mpie = 1'b0; m_ie = 32'h0; m_tvec = P_MTVEC_RST;
      m_epc = 32'h0; m_cause = 32'h0; m_cyc = 64'h0; m_ins = 64'h0;
    end else begin
      a = bus.csr_addr;
      d = bus.csr_wdata;
      w = bus.csr_we && m_impl(a) && !m_ro(a);
      old_mie = m_mie;
      old_mpie = m_mpie;
      if (w && a == 12'hB00)      m_cyc = {m_cyc[63:32], d};
      else if (w && a == 12'hB80) m_cyc = {d, m_cyc[31:0]};
      else                        m_cyc = m_cyc + 64'd1;
      if (w && a == 12'hB02)      m_ins = {m_ins[63:32], d};
      else if (w && a == 12'hB82) m_ins = {d, m_ins[31:0]};
      else if (retire)            m_ins = m_ins + 64'd1;
      if (trap_req) begin
        m_epc = {trap_pc[31:2], 2'b00};
        m_cause = trap_cause;
        m_mpie = old_mie;
        m_mie = 1'b0;
      end else if (mret) begin
        m_mie = old_mpie;
        m_mpie = 1'b1;
      end else if (w) begin
        if (a == 12'h300) begin m_mie = d[3]; m_mpie = d[7]; end
        if (a == 12'h341) m_epc = {d[31:2], 2'b00};
        if (a == 12'h342) m_cause = d;
      end
      if (w && a == 12'h304) m_ie = d & 32'h0000_0880;
      if (w && a == 12'h305) m_tvec = {d[31:2], 2'b00};
    end
  end

  // Per-cycle comparison of every combinational output
  always @(negedge clk) begin
    chk("rdata", bus.csr_rdata, m_read(bus.csr_addr));
    chk("illegal", 32'(bus.csr_illegal),
        32'(!m_impl(bus.csr_addr) || (bus.csr_we && m_ro(bus.csr_addr))));
    chk("irq_pending", 32'(irq_pending),
        32'(m_mie && ((ext_irq && m_ie[11]) || (timer_irq && m_ie[7]))));
    chk("mtvec_out", mtvec_out, m_tvec);
    chk("mepc_out", mepc_out, m_epc);
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.csr_we = 1'b0; bus.csr_wdata = 32'h0; bus.csr_addr = 12'h300;
    retire = 1'b0; trap_req = 1'b0; mret = 1'b0;
  endtask

  task automatic wr(input logic [11:0] a, input logic [31:0] d);
    bus.csr_addr = a; bus.csr_we = 1'b1; bus.csr_wdata = d;
    cyc();
    bus.csr_we = 1'b0;
  endtask

  task automatic rd(input string name, input logic [11:0] a, input logic [31:0] exp);
    bus.csr_addr = a; bus.csr_we = 1'b0;
    #1;
    chk(name, bus.csr_rdata, exp);
  endtask

  logic [11:0] pool [15] = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h344,
                             12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                             12'hC02, 12'hC82, 12'hF14};

  initial begin
    rst = 1'b1; ext_irq = 1'b1; timer_irq = 1'b1;
    trap_cause = 32'h0; trap_pc = 32'h0;
    idle_inputs();

    // Reset values visible while reset is held
    repeat (3) cyc();
    chk("rst_mtvec_out", mtvec_out, P_MTVEC_RST);
    chk("rst_mepc_out", mepc_out, 32'h0);
    chk("rst_irq", 32'(irq_pending), 32'h0);
    rd("rst_rd_mtvec", 12'h305, P_MTVEC_RST);
    rst = 1'b0; ext_irq = 1'b0; timer_irq = 1'b0;
    cyc();
    rd("rd_mtvec", 12'h305, P_MTVEC_RST);
    rd("rd_mstatus", 12'h300, 32'h0000_1800);
    rd("rd_hartid", 12'hF14, P_HART_ID);

    // mcycle wrap through both halves
    wr(12'hB00, 32'hFFFF_FFFF);
    wr(12'hB80, 32'hFFFF_FFFF);
    cyc(); cyc();
    rd("mcycle_wrap_lo", 12'hB00, 32'h1);
    rd("mcycle_wrap_hi", 12'hB80, 32'h0);
    rd("cycle_shadow_lo", 12'hC00, 32'h1);
    rd("cycle_shadow_hi", 12'hC80, 32'h0);

    // External interrupt, then trap entry
    wr(12'h300, 32'h0000_0008);
    wr(12'h304, 32'h0000_0800);
    ext_irq = 1'b1;
    #1;
    chk("irq_same_cycle", 32'(irq_pending), 32'h1);
    trap_req = 1'b1; trap_cause = CAUSE_M_EXT_IRQ; trap_pc = 32'h0000_0104;
    cyc();
    trap_req = 1'b0;
    chk("trap_mepc", mepc_out, 32'h0000_0104);
    chk("trap_irq_masked", 32'(irq_pending), 32'h0);
    rd("trap_mcause", 12'h342, 32'h8000_000B);
    rd("trap_mstatus", 12'h300, 32'h0000_1880);
    ext_irq = 1'b0;

    // Trap beats a same-cycle mepc write; mret restores MIE
    wr(12'h300, 32'h0000_0008);
    trap_req = 1'b1; trap_cause = CAUSE_BREAKPOINT; trap_pc = 32'h0000_0302;
    bus.csr_addr = 12'h341; bus.csr_we = 1'b1; bus.csr_wdata = 32'h0000_0200;
    cyc();
    trap_req = 1'b0; bus.csr_we = 1'b0;
    chk("trap_wins_mepc", mepc_out, 32'h0000_0300);
    rd("trap_wins_mstatus", 12'h300, 32'h0000_1880);
    mret = 1'b1;
    cyc();
    mret = 1'b0;
    rd("mret_mstatus", 12'h300, 32'h0000_1888);

    // Illegal accesses leave state alone
    bus.csr_addr = 12'h7FF; bus.csr_we = 1'b1; bus.csr_wdata = 32'hDEAD_BEEF;
    #1;
    chk("illegal_unimpl", 32'(bus.csr_illegal), 32'h1);
    chk("unimpl_reads0", bus.csr_rdata, 32'h0);
    bus.csr_addr = 12'hC00;
    #1;
    chk("illegal_ro", 32'(bus.csr_illegal), 32'h1);
    cyc();
    bus.csr_we = 1'b0;
    #1;
    chk("ro_read_legal", 32'(bus.csr_illegal), 32'h0);
    rd("mstatus_kept", 12'h300, 32'h0000_1888);
    wr(12'hF14, 32'hFFFF_FFFF);
    rd("hartid_kept", 12'hF14, P_HART_ID);

    // Five retirements
    wr(12'hB02, 32'h0);
    wr(12'hB82, 32'h0);
    retire = 1'b1;
    repeat (5) cyc();
    retire = 1'b0;
    rd("minstret_5", 12'hB02, 32'h5);
    rd("instret_5", 12'hC02, 32'h5);
    rd("instreth_0", 12'hC82, 32'h0);

    // Timer interrupt enable path
    wr(12'h304, 32'h0000_0080);
    wr(12'h300, 32'h0000_0008);
    timer_irq = 1'b1;
    #1;
    chk("timer_irq", 32'(irq_pending), 32'h1);
    chk("timer_cause_const", CAUSE_M_TIMER_IRQ, 32'h8000_0007 ^ 32'(bus.csr_we));

    // Randomized traffic checked each cycle by the compare process
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      bus.csr_addr  = ($urandom_range(0, 3) != 0) ? pool[$urandom_range(0, 14)]
                                                  : 12'($urandom);
      bus.csr_we    = ($urandom_range(0, 9) < 4);
      bus.csr_wdata = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      retire        = $urandom_range(0, 1);
      trap_req      = ($urandom_range(0, 19) == 0);
      mret          = ($urandom_range(0, 19) == 0);
      trap_cause    = $urandom;
      trap_pc       = $urandom;
      if ($urandom_range(0, 9) < 3) ext_irq = ~ext_irq;
      if ($urandom_range(0, 9) < 3) timer_irq = ~timer_irq;
      cyc();
    end
    rst = 1'b0;
    idle_inputs();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 Parameter MTVEC_RST, default 32'h0000_0000, is the reset value of mtvec.
REQ-002 Parameter HART_ID, default 32'h0, is the constant value returned by mhartid.
REQ-003 Clock and reset ports SHALL be: clk  in  1  single clock, rising-edge; rst  in  1  asynchronous, active-high reset.
REQ-004 Port csr_addr  in  12  CSR address of the current instruction.
REQ-005 Port csr_rdata  out  32  combinational read data, which feeds the CSR write-data ALU as its old-value operand.
REQ-006 Port csr_we  in  1  commits csr_wdata to csr_addr at the next rising edge.
REQ-007 Port csr_wdata  in  32  final write value from the CSR write-data ALU (write/set/clear already applied).
REQ-008 Port csr_illegal  out  1  combinational; high when csr_addr is unimplemented, or when csr_we targets a read-only address.
REQ-009 Port retire  in  1  one instruction retires this cycle.
REQ-010 Ports trap_req  in  1, trap_cause  in  32, trap_pc  in  32  carry trap entry request, cause code and faulting PC.
REQ-011 Port mret  in  1  return-from-trap executes this cycle.
REQ-012 Ports ext_irq  in  1 and timer_irq  in  1  are level interrupt sources, already synchronous to clk.
REQ-013 Port irq_pending  out  1  is an enabled interrupt that the core must take.
REQ-014 Ports mtvec_out  out  32 and mepc_out  out  32  are the trap target and the return target.

Function
REQ-015 The map SHALL be: mstatus 0x300 (MIE[3], MPIE[7], MPP[12:11] read 2'b11, all other bits 0); mie 0x304 (MTIE[7], MEIE[11]); mtvec 0x305 (bits[1:0] forced 0); mepc 0x341 (bits[1:0] forced 0); mcause 0x342; mip 0x344 (read-only, MTIP[7]=timer_irq, MEIP[11]=ext_irq).
REQ-016 The counter map SHALL be: mcycle 0xB00, mcycleh 0xB80, minstret 0xB02, minstreth 0xB82 (read/write); cycle 0xC00, cycleh 0xC80, instret 0xC02, instreth 0xC82 (read-only shadows); mhartid 0xF14 (read-only, HART_ID).
REQ-017 Reads SHALL be combinational with zero latency; an unimplemented address SHALL read 0.
REQ-018 Writes SHALL take effect at the rising edge after csr_we; writes to read-only or unimplemented addresses SHALL be ignored.
REQ-019 The 64-bit mcycle SHALL increment every cycle; the 64-bit minstret SHALL increment when retire=1; both SHALL wrap from 2^64-1 to 0.
REQ-020 A csr_we to any half of a counter SHALL load that half with csr_wdata and suppress that counter's increment for that cycle; the other half SHALL be held.
REQ-021 On trap_req, next edge: mepc<=trap_pc&~3, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-022 On mret, next edge: MIE<=MPIE, MPIE<=1.
REQ-023 Write priority per cycle SHALL be trap_req > mret > csr_we to mstatus/mepc/mcause; the losing writes are dropped, and counters are unaffected by this priority.
REQ-024 irq_pending SHALL equal MIE & ((MEIP&MEIE)|(MTIP&MTIE)), combinational from current register state.
REQ-025 mtvec_out and mepc_out SHALL present the current register values with no added latency.

Reset
REQ-026 While rst=1, all registers SHALL clear asynchronously: mstatus MIE=MPIE=0, mie=0, mepc=0, mcause=0, counters=0, mtvec=MTVEC_RST.
REQ-027 Outputs during reset SHALL be: irq_pending=0, mepc_out=0, mtvec_out=MTVEC_RST, csr_rdata per csr_addr using reset values.
REQ-028 An increment or write coincident with reset assertion SHALL be lost; counting SHALL resume at the first edge after rst falls.

Structure
REQ-029 CSR address constants, the mstatus/mie/mip bit-index constants and the cause-code constants SHALL live in a shared package, csr_pkg.
REQ-030 The 64-bit wrap counter with split-half load SHALL be one sub-module, csr_counter64, instantiated twice (mcycle, minstret); everything else stays flat.

Verification
REQ-031 Reset, then read 0x305 -> MTVEC_RST; read 0x300 -> 32'h0000_1800; read 0xF14 -> HART_ID.
REQ-032 Write mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF, then idle 2 cycles -> mcycle/mcycleh read 1/0 (wrap), cycle shadow matches.
REQ-033 Set MIE=1, mie=0x800, pulse ext_irq -> irq_pending=1 the same cycle; trap_req with cause 0x8000_000B at pc 0x104 -> mepc=0x104, mcause=0x8000_000B, MIE=0, MPIE=1, irq_pending=0.
REQ-034 Same cycle trap_req and csr_we to mepc=0x200 -> mepc holds trap_pc; then mret -> MIE=1, MPIE=1.
REQ-035 csr_we to 0xC00 and to 0x7FF -> csr_illegal=1, no state change; retire held for 5 cycles -> minstret advances by 5.
